// File: rtl/num_entry.sv
// num_entry: turns keypad events into the number shown on the seven-segment
// display. It also hands finished operands to the ALU and shows ALU results.
//
// Ports
//   clk_i, rst_ni           clock and asynchronous active-low reset
//   key_i/key_valid_i       key event: 0-9 digit, 10 dp, 11 bksp, 12 clr, 13 enter
//   key_ready_o             key accepted when valid && ready
//   result_i/result_valid_i ALU result and its single-cycle strobe
//   operand_o/_valid_o      committed operand, valid/ready handshake to the ALU
//   operand_ready_i
//   num_o                   number to display (registered)
//   override_shift_amount_o keeps typed trailing fraction zeros visible
//   new_shift_amount_o      shift used with the override (always 0)

package calc_pkg;
  localparam int NumDigits = 8;
  localparam int ExpW      = $clog2(NumDigits);
  typedef struct packed {
    logic [4*NumDigits-1:0] significand;
    logic [ExpW-1:0]        exponent;
  } num_t;
endpackage

module num_entry #(
  parameter int NumDigits = calc_pkg::NumDigits
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [3:0]     key_i,
  input  logic           key_valid_i,
  output logic           key_ready_o,
  input  calc_pkg::num_t result_i,
  input  logic           result_valid_i,
  output calc_pkg::num_t operand_o,
  output logic           operand_valid_o,
  input  logic           operand_ready_i,
  output calc_pkg::num_t num_o,
  output logic           override_shift_amount_o,
  output logic [2:0]     new_shift_amount_o
);
  localparam int SW = 4 * NumDigits;
  localparam int EW = calc_pkg::ExpW;
  localparam int CW = $clog2(NumDigits + 1);

  localparam logic [1:0] SHOW  = 2'd0;
  localparam logic [1:0] ENTRY = 2'd1;
  localparam logic [1:0] SEND  = 2'd2;

  localparam calc_pkg::num_t ZERO = '{significand: '0, exponent: EW'(NumDigits - 1)};

  logic [1:0]     state, state_n;
  logic [SW-1:0]  digits, digits_n;   // typed digits, right-aligned
  logic [CW-1:0]  count, count_n;     // digits typed, incl. implicit leading 0
  logic [CW-1:0]  frac, frac_n;       // digits after the decimal point
  logic           dp, dp_n;
  calc_pkg::num_t num_n, opnd_n;
  logic           opv_n, ovr_n, accept;

  assign key_ready_o        = (state != SEND) && !result_valid_i;
  assign new_shift_amount_o = 3'd0;
  assign accept             = key_valid_i && key_ready_o;

  always_comb begin
    state_n  = state;
    digits_n = digits;
    count_n  = count;
    frac_n   = frac;
    dp_n     = dp;
    num_n    = num_o;
    opnd_n   = operand_o;
    opv_n    = operand_valid_o;

    // Handshake completes independently of any result arriving in SEND.
    if (state == SEND && operand_valid_o && operand_ready_i) begin
      opv_n   = 1'b0;
      state_n = SHOW;
    end

    if (result_valid_i) begin
      digits_n = '0;
      count_n  = '0;
      frac_n   = '0;
      dp_n     = 1'b0;
      num_n    = result_i;
      if (state != SEND) state_n = SHOW;
    end else if (accept) begin
      // Digit or dp typed over a displayed value starts a fresh entry.
      if (key_i <= 4'd10 && state == SHOW) begin
        digits_n = '0;
        count_n  = '0;
        frac_n   = '0;
        dp_n     = 1'b0;
        state_n  = ENTRY;
      end

      if (key_i <= 4'd9) begin
        if (count_n == CW'(NumDigits)) begin
          // buffer full: key consumed, nothing changes
        end else if (key_i == 4'd0 && count_n == '0 && !dp_n) begin
          // leading zero is not stored
        end else begin
          digits_n = {digits_n[SW-5:0], key_i};
          count_n  = count_n + CW'(1);
          if (dp_n) frac_n = frac_n + CW'(1);
        end
      end else if (key_i == 4'd10) begin
        if (!dp_n && count_n != CW'(NumDigits)) begin
          if (count_n == '0) count_n = CW'(1);
          dp_n = 1'b1;
        end
      end else if (key_i == 4'd11) begin
        if (state == ENTRY) begin
          if (dp_n && frac_n == '0) begin
            dp_n = 1'b0;
            if (digits_n == '0) count_n = '0;
          end else if (count_n != '0) begin
            digits_n = {4'h0, digits_n[SW-1:4]};
            count_n  = count_n - CW'(1);
            if (frac_n != '0) frac_n = frac_n - CW'(1);
          end
        end
      end else if (key_i == 4'd12) begin
        digits_n = '0;
        count_n  = '0;
        frac_n   = '0;
        dp_n     = 1'b0;
        num_n    = ZERO;
        state_n  = SHOW;
      end else if (key_i == 4'd13) begin
        // In SHOW this forwards the displayed result as the next operand.
        opnd_n  = num_o;
        opv_n   = 1'b1;
        state_n = SEND;
      end

      if (state_n == ENTRY) begin
        num_n.significand = digits_n;
        num_n.exponent    = EW'(NumDigits - 1) - EW'(frac_n);
      end
    end

    ovr_n = (state_n == ENTRY) && dp_n;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                   <= SHOW;
      digits                  <= '0;
      count                   <= '0;
      frac                    <= '0;
      dp                      <= 1'b0;
      num_o                   <= ZERO;
      operand_o               <= ZERO;
      operand_valid_o         <= 1'b0;
      override_shift_amount_o <= 1'b0;
    end else begin
      state                   <= state_n;
      digits                  <= digits_n;
      count                   <= count_n;
      frac                    <= frac_n;
      dp                      <= dp_n;
      num_o                   <= num_n;
      operand_o               <= opnd_n;
      operand_valid_o         <= opv_n;
      override_shift_amount_o <= ovr_n;
    end
  end
endmodule
